button_reader: RTL and testbench
================================

// Module: button_reader
// PURPOSE
//  Input-side counterpart of the board LED driver: samples raw pushbuttons, synchronises and debounces them.
//  Emits clean pressed levels, 1-cycle press/release pulses and a per-button toggle latch.
//  The toggle latch is wired straight to LED outputs in board tops.
//  Sits between board pins and user logic; one instance per board top.
// PARAMETERS
//  NBTN            3      number of buttons (1..8)
//  DEBOUNCE_CYCLES 12000  cycles input must stay stable before accepted (>=2; 1 ms at 12 MHz)
//  ACTIVE_LOW      1      1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//  CNT_W           $clog2(DEBOUNCE_CYCLES) (localparam, derived; not overridable)
// PORTS
//  clk      in   1     system clock
//  rstn     in   1     asynchronous active-low reset
//  BTN      in   NBTN  raw button pins, asynchronous to clk
//  pressed  out  NBTN  debounced level, 1 = held down
//  press    out  NBTN  1-cycle pulse on accepted press
//  release  out  NBTN  1-cycle pulse on accepted release
//  LED      out  NBTN  toggle latch, flips on each accepted press
// BEHAVIOUR
//  Reset (rstn=0, async):
//   - pressed, press, release, LED and all counters = 0.
//   - Synchroniser flops load the released pin level (ACTIVE_LOW ? 1 : 0).
//  Synchroniser: per bit, 2 flops. Normalised raw r = sync2 ^ ACTIVE_LOW, so 1 = pressed.
//  Per-button debounce (all buttons independent and identical):
//   - r == pressed: cnt <= 0.
//   - r != pressed and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - r != pressed and cnt == DEBOUNCE_CYCLES-1:
//     pressed <= r, cnt <= 0, press <= r, release <= ~r.
//   - press and release are 0 in every other cycle. Both are registered.
//   - press/release assert in the same cycle as the pressed change, never both at once.
//  LED[i] <= ~LED[i] in the cycle press[i] is registered.
//   - LED[i] therefore changes 1 cycle after press[i] is seen high.
//  Latency:
//   - Pin changes before edge k and then holds.
//   - sync2 reflects it after edge k+1.
//   - pressed/press/release update at edge k+1+DEBOUNCE_CYCLES.
//  Glitch rejection:
//   - A mismatch lasting < DEBOUNCE_CYCLES cycles is discarded: cnt returns to 0 on any match cycle.
//   - No output change results.
//  Counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around.
//  Bounce at the threshold: if r reverts in the same cycle cnt == DEBOUNCE_CYCLES-1, the change is not accepted.
//  Reset mid-debounce:
//   - Count and outputs clear immediately.
//   - A button still held when rstn rises is reported as a fresh press after the full latency.
//  Simultaneous events on different buttons are handled independently in the same cycle.
// TESTING (ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, NBTN=3)
//  - Reset: rstn=0 with BTN=3'b000 -> pressed=0, LED=0, press=0; hold 10 cycles, no pulses.
//  - Clean press: BTN[0] 1->0 before edge k, held
//     -> press[0]=1 for one cycle after edge k+5; pressed[0]=1 thereafter; LED[0]=1 one cycle later.
//  - Glitch: BTN[1] low for 3 cycles, then high -> no press/release, pressed[1] stays 0.
//  - Bounce: BTN[2] toggles every 2 cycles for 20 cycles, then holds low
//     -> exactly one press[2], 5 cycles after the final transition.
//  - Release & toggle: press/release BTN[0] twice
//     -> 2 press and 2 release pulses; LED[0] ends at 0; pulses never overlap.
//  - Reset mid-operation: assert rstn after 2 cycles of mismatch with BTN[0] held low
//     -> all outputs 0; press[0] occurs 5 cycles after rstn deassertion.

Source files
------------

// File: rtl/button_reader.sv
// Pushbutton front end: two-flop synchroniser, per-button debounce counter,
// registered press/release pulses and a toggle latch per button for LEDs.
module button_reader #(
  parameter int NBTN            = 3,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NBTN-1:0] BTN,
  output logic [NBTN-1:0] pressed,
  output logic [NBTN-1:0] press,
  output logic [NBTN-1:0] release_pulse,
  output logic [NBTN-1:0] LED
);

  localparam int              CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NBTN-1:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? {NBTN{1'b1}} : {NBTN{1'b0}};

  logic [NBTN-1:0]  sync1_q, sync2_q;
  logic [NBTN-1:0]  raw;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];
  logic [NBTN-1:0]  pressed_q, pressed_d;
  logic [NBTN-1:0]  press_q, press_d;
  logic [NBTN-1:0]  release_q, release_d;
  logic [NBTN-1:0]  led_q, led_d;

  // Normalised so that 1 always means "held down" regardless of pin polarity.
  assign raw = sync2_q ^ IDLE_LEVEL;

  always_comb begin
    pressed_d = pressed_q;
    press_d   = '0;
    release_d = '0;
    led_d     = led_q ^ press_q;
    for (int i = 0; i < NBTN; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != pressed_q[i]) begin
        // A reversion on the threshold cycle lands in the match branch instead, so it is never accepted.
        if (cnt_q[i] == CNT_MAX) begin
          pressed_d[i] = raw[i];
          press_d[i]   = raw[i];
          release_d[i] = ~raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= IDLE_LEVEL;
      sync2_q   <= IDLE_LEVEL;
      pressed_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      led_q     <= '0;
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= BTN;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      led_q     <= led_d;
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pressed       = pressed_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign LED           = led_q;

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader: reference model compares every cycle,
// plus a vector table and directed multi-cycle scenarios.
module tb_button_reader;

   localparam int NBTN = 3;
   localparam int DEB  = 4;

   logic            clk = 1'b0;
   logic            rstn;
   logic [NBTN-1:0] BTN;
   logic [NBTN-1:0] pressed;
   logic [NBTN-1:0] press;
   logic [NBTN-1:0] releasePulse;
   logic [NBTN-1:0] LED;

   button_reader #(
      .NBTN(NBTN),
      .DEBOUNCE_CYCLES(DEB),
      .ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .BTN(BTN),
      .pressed(pressed),
      .press(press),
      .release_pulse(releasePulse),
      .LED(LED)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: debounced level, pulses and toggle latch per button
   logic [NBTN-1:0] stateM;
   logic [NBTN-1:0] pressM;
   logic [NBTN-1:0] releaseM;
   logic [NBTN-1:0] ledM;
   bit              histM [NBTN][$];
   bit              allDiff;

   // Per-tick counters used by the directed scenarios
   int pressCnt;
   int relCnt;
   int firstPressTick;
   int tickNo;

   typedef struct {
      logic [NBTN-1:0] btn;
      int              cycles;
      logic [NBTN-1:0] expPressed;
      logic [NBTN-1:0] expLed;
   } vec_t;

   vec_t vecs [8];

   // History of normalised pin samples, prefilled with "released" to stand in
   // for the synchroniser's reset contents
   task automatic resetModel();
      for (int b = 0; b < NBTN; b++) begin
         histM[b].delete();
         repeat (DEB + 1) histM[b].push_back(1'b0);
      end
      stateM   = '0;
      pressM   = '0;
      releaseM = '0;
      ledM     = '0;
   endtask

   // A level is accepted once the DEB most recent synchronised samples
   // (pin samples taken two edges ago and earlier) all disagree with it
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         resetModel();
      end else begin
         for (int b = 0; b < NBTN; b++) begin
            ledM[b]     = ledM[b] ^ pressM[b];
            pressM[b]   = 1'b0;
            releaseM[b] = 1'b0;
            histM[b].push_back(~BTN[b]);
            allDiff = 1'b1;
            for (int j = histM[b].size() - DEB - 2; j <= histM[b].size() - 3; j++) begin
               if (histM[b][j] == stateM[b]) allDiff = 1'b0;
            end
            if (allDiff) begin
               stateM[b]   = ~stateM[b];
               pressM[b]   = stateM[b];
               releaseM[b] = ~stateM[b];
            end
            if (histM[b].size() > 16) void'(histM[b].pop_front());
         end
      end
   end

   task automatic checkOutput(input string name, input logic [NBTN-1:0] act, input logic [NBTN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkCount(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NBTN-1:0] b);
      BTN = b;
   endtask

   // Advance one edge, then compare the DUT against the model away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
      checkOutput("pressed", pressed, stateM);
      checkOutput("press", press, pressM);
      checkOutput("release", releasePulse, releaseM);
      checkOutput("led", LED, ledM);
      checkOutput("overlap", press & releasePulse, '0);
   endtask

   task automatic clearCounters();
      pressCnt       = 0;
      relCnt         = 0;
      firstPressTick = -1;
      tickNo         = 0;
   endtask

   task automatic runTicks(input int n, input int b);
      for (int t = 0; t < n; t++) begin
         tick();
         tickNo++;
         if (press[b]) begin
            pressCnt++;
            if (firstPressTick < 0) firstPressTick = tickNo;
         end
         if (releasePulse[b]) relCnt++;
      end
   endtask

   initial begin
      logic led6;
      logic led7;

      vecs[0] = '{3'b111, 8, 3'b000, 3'b000};
      vecs[1] = '{3'b110, 8, 3'b001, 3'b001};
      vecs[2] = '{3'b111, 8, 3'b000, 3'b001};
      vecs[3] = '{3'b100, 8, 3'b011, 3'b010};
      vecs[4] = '{3'b101, 3, 3'b011, 3'b010};
      vecs[5] = '{3'b100, 8, 3'b011, 3'b010};
      vecs[6] = '{3'b011, 8, 3'b100, 3'b110};
      vecs[7] = '{3'b111, 8, 3'b000, 3'b110};

      // Reset held with every pin reading pressed: nothing may come out
      BTN  = 3'b000;
      rstn = 1'b0;
      resetModel();
      clearCounters();
      for (int b = 0; b < NBTN; b++) begin
         runTicks(10, b);
      end
      checkOutput("reset_outputs", pressed | press | releasePulse | LED, 3'b000);
      checkCount("reset_pulses", pressCnt + relCnt, 0);

      applyStimulus(3'b111);
      tick();
      rstn = 1'b1;

      // Table of held input patterns and the settled outputs they must give
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].btn);
         repeat (vecs[v].cycles) tick();
         checkOutput($sformatf("vec%0d_pressed", v), pressed, vecs[v].expPressed);
         checkOutput($sformatf("vec%0d_led", v), LED, vecs[v].expLed);
      end

      // Clean press of button 0: pulse on the sixth edge, LED one edge later
      applyStimulus(3'b110);
      firstPressTick = -1;
      led6 = 1'b1;
      led7 = 1'b0;
      for (int t = 1; t <= 10; t++) begin
         tick();
         if (press[0] && firstPressTick < 0) firstPressTick = t;
         if (t == 6) led6 = LED[0];
         if (t == 7) led7 = LED[0];
      end
      checkCount("clean_press_latency", firstPressTick, 6);
      checkOutput("clean_led_before", {2'b00, led6}, 3'b000);
      checkOutput("clean_led_after", {2'b00, led7}, 3'b001);
      checkOutput("clean_pressed", {2'b00, pressed[0]}, 3'b001);
      applyStimulus(3'b111);
      repeat (10) tick();

      // Three-cycle glitch on button 1 must be discarded
      clearCounters();
      applyStimulus(3'b101);
      runTicks(3, 1);
      applyStimulus(3'b111);
      runTicks(10, 1);
      checkCount("glitch_pulses", pressCnt + relCnt, 0);
      checkOutput("glitch_pressed", {2'b00, pressed[1]}, 3'b000);

      // Bounce on button 2, then a steady press
      clearCounters();
      for (int t = 0; t < 10; t++) begin
         applyStimulus((t % 2 == 0) ? 3'b011 : 3'b111);
         runTicks(2, 2);
      end
      checkCount("bounce_early_press", pressCnt, 0);
      clearCounters();
      applyStimulus(3'b011);
      runTicks(10, 2);
      checkCount("bounce_press_count", pressCnt, 1);
      checkCount("bounce_press_latency", firstPressTick, 6);
      applyStimulus(3'b111);
      repeat (10) tick();

      // Two press/release cycles on button 0 from a freshly reset LED
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      clearCounters();
      for (int r = 0; r < 2; r++) begin
         applyStimulus(3'b110);
         runTicks(8, 0);
         applyStimulus(3'b111);
         runTicks(8, 0);
      end
      checkCount("toggle_press_count", pressCnt, 2);
      checkCount("toggle_release_count", relCnt, 2);
      checkOutput("toggle_led_end", {2'b00, LED[0]}, 3'b000);

      // Reset arriving mid-debounce while button 0 stays held
      applyStimulus(3'b110);
      tick();
      tick();
      rstn = 1'b0;
      tick();
      checkOutput("midrst_outputs", pressed | press | releasePulse | LED, 3'b000);
      rstn = 1'b1;
      clearCounters();
      runTicks(12, 0);
      checkCount("midrst_press_latency", firstPressTick, 6);
      checkCount("midrst_press_count", pressCnt, 1);

      // Random pin activity with occasional resets, checked against the model
      for (int s = 0; s < 150; s++) begin
         applyStimulus(3'($urandom_range(0, 7)));
         repeat ($urandom_range(1, 8)) tick();
         if ($urandom_range(0, 24) == 0) begin
            rstn = 1'b0;
            tick();
            rstn = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
